// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the ID-stage main-control decoder: opcode/funct
// values, alu_op and branch_type encodings, the control bundle and FSM states.
package pipe_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGE   = 6'b000001;
    localparam logic [5:0] OP_BGT   = 6'b000111;

    // Funct field (instr[5:0]) of the multi-cycle multiply
    localparam logic [5:0] FN_MULT  = 6'b011000;

    // alu_op encodings
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_SLT    = 2'b11;

    // branch_type encodings
    localparam logic [1:0] BR_BEQ = 2'b00;
    localparam logic [1:0] BR_BGT = 2'b01;
    localparam logic [1:0] BR_BGE = 2'b10;
    localparam logic [1:0] BR_BNE = 2'b11;

    // Control fields carried through the ID/EX register
    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic [1:0] branch_type;
    } ctrl_bundle_t;

    // A bubble has every control field cleared
    localparam ctrl_bundle_t CTRL_BUBBLE = '{
        reg_write:   1'b0,
        alu_src:     1'b0,
        reg_dst:     1'b0,
        branch:      1'b0,
        mem_read:    1'b0,
        mem_write:   1'b0,
        mem_to_reg:  1'b0,
        alu_op:      2'b00,
        branch_type: 2'b00
    };

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_MULT_BUSY = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode/funct decoder producing the control bundle plus
// legality, multiply and rt-usage flags. Unknown opcodes yield a bubble.
// Optional feature macro: PIPE_DECODE_EXT_BRANCH_EN (adds bge/bgt).
module opcode_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t ctrl_o,
    output logic         is_legal_o,
    output logic         is_mult_o,
    output logic         reads_rt_o
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused_bits;

    assign w_opcode      = instr_i[31:26];
    assign w_funct       = instr_i[5:0];
    // Register and immediate fields are not needed to pick control signals
    assign w_unused_bits = ^instr_i[25:6];

    // Table lookup from opcode to control fields; unknown opcodes stay a bubble
    always_comb begin
        ctrl_o     = CTRL_BUBBLE;
        is_legal_o = 1'b0;
        is_mult_o  = 1'b0;
        reads_rt_o = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.alu_op    = ALU_OP_RTYPE;
                is_legal_o       = 1'b1;
                reads_rt_o       = 1'b1;
                is_mult_o        = (w_funct == FN_MULT);
            end
            OP_ADDI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_OP_ADD;
                is_legal_o       = 1'b1;
            end
            OP_SLTI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_OP_SLT;
                is_legal_o       = 1'b1;
            end
            OP_LW: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.alu_op     = ALU_OP_ADD;
                is_legal_o        = 1'b1;
            end
            OP_SW: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_op    = ALU_OP_ADD;
                is_legal_o       = 1'b1;
                reads_rt_o       = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.branch      = 1'b1;
                ctrl_o.alu_op      = ALU_OP_BRANCH;
                ctrl_o.branch_type = BR_BEQ;
                is_legal_o         = 1'b1;
                reads_rt_o         = 1'b1;
            end
            OP_BNE: begin
                ctrl_o.branch      = 1'b1;
                ctrl_o.alu_op      = ALU_OP_BRANCH;
                ctrl_o.branch_type = BR_BNE;
                is_legal_o         = 1'b1;
                reads_rt_o         = 1'b1;
            end
`ifdef PIPE_DECODE_EXT_BRANCH_EN
            OP_BGE: begin
                ctrl_o.branch      = 1'b1;
                ctrl_o.alu_op      = ALU_OP_BRANCH;
                ctrl_o.branch_type = BR_BGE;
                is_legal_o         = 1'b1;
                reads_rt_o         = 1'b1;
            end
            OP_BGT: begin
                ctrl_o.branch      = 1'b1;
                ctrl_o.alu_op      = ALU_OP_BRANCH;
                ctrl_o.branch_type = BR_BGT;
                is_legal_o         = 1'b1;
                reads_rt_o         = 1'b1;
            end
`endif
            default: begin
                ctrl_o     = CTRL_BUBBLE;
                is_legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_decode_ctrl.sv
// Registered main-control decoder for the ID stage: decodes into the ID/EX
// control register, detects load-use hazards, inserts bubbles on flush/stall
// and holds the front end while a multi-cycle multiply occupies EX.
// Optional feature macro: PIPE_DECODE_EXT_BRANCH_EN (bge/bgt opcodes).
module pipe_decode_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MULT_LAT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       instr_i,
    input  logic              valid_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic              ex_reg_write_o,
    output logic              ex_alu_src_o,
    output logic              ex_reg_dst_o,
    output logic              ex_branch_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic              ex_mem_to_reg_o,
    output logic [1:0]        ex_alu_op_o,
    output logic [1:0]        ex_branch_type_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic              illegal_o
);

    // Stall cycles after the mult enters EX, counted down to 1
    localparam logic [3:0] CNT_INIT        = 4'(MULT_LAT - 1);
    localparam logic       MULT_NEEDS_WAIT = (MULT_LAT > 1);

    ctrl_state_e       r_state;
    logic [3:0]        r_cnt;
    ctrl_bundle_t      r_ctrl;
    logic              r_ex_valid;
    logic [REG_AW-1:0] r_ex_rt;
    logic              r_illegal;

    ctrl_bundle_t      w_dec_ctrl;
    logic              w_is_legal;
    logic              w_is_mult;
    logic              w_reads_rt;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic              w_hz;
    logic              w_stall;
    logic              w_accept;

    opcode_decode u_opcode_decode (
        .instr_i    (instr_i),
        .ctrl_o     (w_dec_ctrl),
        .is_legal_o (w_is_legal),
        .is_mult_o  (w_is_mult),
        .reads_rt_o (w_reads_rt)
    );

    assign w_rs = REG_AW'(instr_i[25:21]);
    assign w_rt = REG_AW'(instr_i[20:16]);

    // Load-use hazard: a load in EX writes a non-zero register the ID instruction reads
    always_comb begin
        w_hz = 1'b0;
        if (valid_i && r_ex_valid && r_ctrl.mem_read && (r_ex_rt != {REG_AW{1'b0}})) begin
            if (r_ex_rt == w_rs) begin
                w_hz = 1'b1;
            end else if (w_reads_rt && (r_ex_rt == w_rt)) begin
                w_hz = 1'b1;
            end else begin
                w_hz = 1'b0;
            end
        end else begin
            w_hz = 1'b0;
        end
    end

    assign w_stall  = w_hz | (r_state == ST_MULT_BUSY);
    assign stall_o  = w_stall;
    // A legal instruction actually moving into EX this cycle
    assign w_accept = valid_i & ~flush_i & ~w_stall & w_is_legal;

    // Multiply-busy FSM: counts the EX occupancy of mult; flush does not disturb it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept && w_is_mult && MULT_NEEDS_WAIT) begin
                        r_state <= ST_MULT_BUSY;
                        r_cnt   <= CNT_INIT;
                    end else begin
                        r_state <= ST_RUN;
                        r_cnt   <= 4'd0;
                    end
                end
                ST_MULT_BUSY: begin
                    if (r_cnt <= 4'd1) begin
                        r_state <= ST_RUN;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_state <= ST_MULT_BUSY;
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // ID/EX register: flush, then stall, then empty slot, then decode (illegal -> flagged bubble)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl     <= CTRL_BUBBLE;
            r_ex_valid <= 1'b0;
            r_ex_rt    <= {REG_AW{1'b0}};
            r_illegal  <= 1'b0;
        end else if (flush_i || w_stall || !valid_i) begin
            r_ctrl     <= CTRL_BUBBLE;
            r_ex_valid <= 1'b0;
            r_ex_rt    <= {REG_AW{1'b0}};
            r_illegal  <= 1'b0;
        end else if (w_is_legal) begin
            r_ctrl     <= w_dec_ctrl;
            r_ex_valid <= 1'b1;
            r_ex_rt    <= w_rt;
            r_illegal  <= 1'b0;
        end else begin
            r_ctrl     <= CTRL_BUBBLE;
            r_ex_valid <= 1'b0;
            r_ex_rt    <= {REG_AW{1'b0}};
            r_illegal  <= 1'b1;
        end
    end

    assign ex_valid_o       = r_ex_valid;
    assign ex_reg_write_o   = r_ctrl.reg_write;
    assign ex_alu_src_o     = r_ctrl.alu_src;
    assign ex_reg_dst_o     = r_ctrl.reg_dst;
    assign ex_branch_o      = r_ctrl.branch;
    assign ex_mem_read_o    = r_ctrl.mem_read;
    assign ex_mem_write_o   = r_ctrl.mem_write;
    assign ex_mem_to_reg_o  = r_ctrl.mem_to_reg;
    assign ex_alu_op_o      = r_ctrl.alu_op;
    assign ex_branch_type_o = r_ctrl.branch_type;
    assign ex_rt_o          = r_ex_rt;
    assign illegal_o        = r_illegal;

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Scoreboard bench for pipe_decode_ctrl: directed test-plan sequence followed
// by random traffic, checked against a behavioural pipeline model.
module tb_pipe_decode_ctrl;

    localparam int REG_AW   = 5;
    localparam int MULT_LAT = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [31:0]       instr_i;
    logic              valid_i;
    logic              flush_i;
    logic              stall_o;
    logic              ex_valid_o;
    logic              ex_reg_write_o;
    logic              ex_alu_src_o;
    logic              ex_reg_dst_o;
    logic              ex_branch_o;
    logic              ex_mem_read_o;
    logic              ex_mem_write_o;
    logic              ex_mem_to_reg_o;
    logic [1:0]        ex_alu_op_o;
    logic [1:0]        ex_branch_type_o;
    logic [REG_AW-1:0] ex_rt_o;
    logic              illegal_o;

    always #5 clk_i = ~clk_i;

    pipe_decode_ctrl #(.REG_AW(REG_AW), .MULT_LAT(MULT_LAT)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .instr_i          (instr_i),
        .valid_i          (valid_i),
        .flush_i          (flush_i),
        .stall_o          (stall_o),
        .ex_valid_o       (ex_valid_o),
        .ex_reg_write_o   (ex_reg_write_o),
        .ex_alu_src_o     (ex_alu_src_o),
        .ex_reg_dst_o     (ex_reg_dst_o),
        .ex_branch_o      (ex_branch_o),
        .ex_mem_read_o    (ex_mem_read_o),
        .ex_mem_write_o   (ex_mem_write_o),
        .ex_mem_to_reg_o  (ex_mem_to_reg_o),
        .ex_alu_op_o      (ex_alu_op_o),
        .ex_branch_type_o (ex_branch_type_o),
        .ex_rt_o          (ex_rt_o),
        .illegal_o        (illegal_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int   due;
        logic st;
    } stall_exp_t;

    typedef struct {
        int          due;
        logic [10:0] ctrl;   // {rw,as,rd,br,mr,mw,m2r,alu_op[1:0],branch_type[1:0]}
        logic        v;
        logic [4:0]  rt;
        logic        ill;
    } reg_exp_t;

    stall_exp_t sq[$];
    reg_exp_t   rq[$];

    // Model of what sits in EX and how long a multiply keeps the front end held
    logic        m_valid = 1'b0;
    logic [10:0] m_ctrl  = 11'd0;
    logic [4:0]  m_rt    = 5'd0;
    logic        m_ill   = 1'b0;
    int          m_busy  = 0;

    // Control word from the decode table: {legal, rw,as,rd,br,mr,mw,m2r, alu_op, branch_type}
    function automatic logic [11:0] ref_decode(input logic [5:0] op);
        logic [11:0] r;
        r = 12'h000;
        if (op == 6'b000000)      r = {1'b1, 7'b1010000, 2'b10, 2'b00};
        else if (op == 6'b001000) r = {1'b1, 7'b1100000, 2'b00, 2'b00};
        else if (op == 6'b001010) r = {1'b1, 7'b1100000, 2'b11, 2'b00};
        else if (op == 6'b100011) r = {1'b1, 7'b1100101, 2'b00, 2'b00};
        else if (op == 6'b101011) r = {1'b1, 7'b0100010, 2'b00, 2'b00};
        else if (op == 6'b000100) r = {1'b1, 7'b0001000, 2'b01, 2'b00};
        else if (op == 6'b000101) r = {1'b1, 7'b0001000, 2'b01, 2'b11};
`ifdef PIPE_DECODE_EXT_BRANCH_EN
        else if (op == 6'b000001) r = {1'b1, 7'b0001000, 2'b01, 2'b10};
        else if (op == 6'b000111) r = {1'b1, 7'b0001000, 2'b01, 2'b01};
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Apply one cycle of stimulus and predict the DUT's response
    task automatic drive(input logic r, input logic v, input logic f, input logic [31:0] ins);
        logic [11:0] d;
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic        rr, hz, st;
        stall_exp_t  se;
        reg_exp_t    re;
        @(posedge clk_i);
        #1;
        rst_i   = r;
        valid_i = v;
        flush_i = f;
        instr_i = ins;
        op = ins[31:26];
        rs = ins[25:21];
        rt = ins[20:16];
        d  = ref_decode(op);
        rr = (op == 6'b000000) || (op == 6'b101011) || d[7];
        hz = v && m_valid && m_ctrl[6] && (m_rt != 5'd0) && ((m_rt == rs) || (rr && (m_rt == rt)));
        st = hz || (m_busy > 0);
        se.due = cyc;
        se.st  = st;
        sq.push_back(se);
        if (r) begin
            m_valid = 1'b0; m_ctrl = 11'd0; m_rt = 5'd0; m_ill = 1'b0; m_busy = 0;
        end else begin
            m_ill = 1'b0;
            if (m_busy > 0) m_busy--;
            if (f || st || !v) begin
                m_valid = 1'b0; m_ctrl = 11'd0; m_rt = 5'd0;
            end else if (d[11]) begin
                m_valid = 1'b1; m_ctrl = d[10:0]; m_rt = rt;
                if (op == 6'b000000 && ins[5:0] == 6'b011000 && MULT_LAT > 1) m_busy = MULT_LAT - 1;
            end else begin
                m_valid = 1'b0; m_ctrl = 11'd0; m_rt = 5'd0; m_ill = 1'b1;
            end
        end
        re.due  = cyc + 1;
        re.ctrl = m_ctrl;
        re.v    = m_valid;
        re.rt   = m_rt;
        re.ill  = m_ill;
        rq.push_back(re);
    endtask

    // Compare every expectation that has come due against what the DUT presents
    task automatic monitor_step();
        stall_exp_t  se;
        reg_exp_t    re;
        logic [10:0] act;
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            se = sq.pop_front();
            check("stall_o", 32'(stall_o), 32'(se.st));
        end
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            re  = rq.pop_front();
            act = {ex_reg_write_o, ex_alu_src_o, ex_reg_dst_o, ex_branch_o, ex_mem_read_o,
                   ex_mem_write_o, ex_mem_to_reg_o, ex_alu_op_o, ex_branch_type_o};
            check("idex_ctrl",  32'(act),        32'(re.ctrl));
            check("ex_valid_o", 32'(ex_valid_o), 32'(re.v));
            check("ex_rt_o",    32'(ex_rt_o),    32'(re.rt));
            check("illegal_o",  32'(illegal_o),  32'(re.ill));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            monitor_step();
        end
    end

    localparam logic [31:0] I_LW3  = 32'h8C430004;  // lw  $3, 4($2)
    localparam logic [31:0] I_LW0  = 32'h8C400004;  // lw  $0, 4($2)
    localparam logic [31:0] I_ADD  = 32'h00642820;  // add $5, $3, $4
    localparam logic [31:0] I_MULT = 32'h00220018;  // mult $1, $2
    localparam logic [31:0] I_ADDI = 32'h20210001;  // addi $1, $1, 1
    localparam logic [31:0] I_ILL  = 32'hFC000000;  // opcode 111111
    localparam logic [31:0] I_BGT  = 32'h1C220003;  // opcode 000111

    logic [5:0]  ops [12];
    logic [5:0]  op;
    logic [31:0] ins;

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        instr_i = 32'h0;
        ops = '{6'b000000, 6'b001000, 6'b001010, 6'b100011, 6'b101011, 6'b000100,
                6'b000101, 6'b000001, 6'b000111, 6'b111111, 6'b100011, 6'b000000};

        // Directed sequence (stalled cycles repeat the held IF/ID instruction)
        drive(1'b1, 1'b0, 1'b0, 32'h0);     // reset
        drive(1'b0, 1'b1, 1'b0, I_LW3);     // lw $3
        drive(1'b0, 1'b1, 1'b0, I_ADD);     // load-use stall
        drive(1'b0, 1'b1, 1'b0, I_ADD);     // add issues
        drive(1'b0, 1'b1, 1'b0, I_LW0);     // lw $0
        drive(1'b0, 1'b1, 1'b0, I_ADD);     // no stall
        drive(1'b0, 1'b1, 1'b0, I_MULT);    // mult accepted
        drive(1'b0, 1'b1, 1'b0, I_ADDI);    // busy
        drive(1'b0, 1'b1, 1'b0, I_ADDI);    // busy
        drive(1'b0, 1'b1, 1'b0, I_ADDI);    // busy
        drive(1'b0, 1'b1, 1'b0, I_ADDI);    // addi issues
        drive(1'b0, 1'b1, 1'b0, I_LW3);
        drive(1'b0, 1'b1, 1'b1, I_ADD);     // flush + hazard
        drive(1'b0, 1'b1, 1'b1, I_LW3);     // flushed lw
        drive(1'b0, 1'b1, 1'b0, I_ILL);     // illegal pulse
        drive(1'b0, 1'b1, 1'b0, I_BGT);     // bgt or illegal per build
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, I_MULT);
        drive(1'b0, 1'b1, 1'b0, I_ADDI);    // 1st busy cycle
        drive(1'b1, 1'b1, 1'b0, I_ADDI);    // reset on 2nd busy cycle
        drive(1'b0, 1'b0, 1'b0, 32'h0);     // back in RUN, all clear
        drive(1'b0, 1'b1, 1'b0, I_ADDI);

        // Random traffic with a small register pool to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            op = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 15) == 0) op = 6'($urandom);
            ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            if (op == 6'b000000) ins[5:0] = ($urandom_range(0, 3) == 0) ? 6'b011000 : 6'b100000;
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) == 0), ins);
        end

        repeat (3) @(posedge clk_i);
        #1;
        check("sb_drain", 32'(sq.size() + rq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
